// File: rtl/operand_loader.sv
// Operand loader: turns a valid/ready byte stream into load-A / load-B / swap strobes
// for the two-register operand file, and counts completed pairs.
module operand_loader #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             swap_req,
    input  logic             abort,
    output logic [WIDTH-1:0] data_out,
    output logic             load_a,
    output logic             load_b,
    output logic             swap,
    output logic             pair_done,
    output logic [WIDTH-1:0] pair_count
);

    typedef enum logic [1:0] {
        StWaitA,
        StWaitB,
        StSwap,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             load_a_q, load_a_d;
    logic             load_b_q, load_b_d;
    logic             swap_q, swap_d;
    logic             done_q, done_d;
    logic             swap_pending_q, swap_pending_d;
    logic             handshake;

    always_comb begin
        state_d        = state_q;
        data_d         = data_q;
        count_d        = count_q;
        load_a_d       = 1'b0;
        load_b_d       = 1'b0;
        swap_d         = 1'b0;
        done_d         = 1'b0;
        swap_pending_d = swap_pending_q;

        // Ready is also gated by reset so upstream never sees a handshake during reset.
        in_ready  = reset && !abort && ((state_q == StWaitA) || (state_q == StWaitB));
        handshake = in_valid && in_ready;

        unique case (state_q)
            StWaitA: begin
                if (handshake) begin
                    data_d         = in_data;
                    load_a_d       = 1'b1;
                    swap_pending_d = swap_req;
                    state_d        = StWaitB;
                end
            end
            StWaitB: begin
                if (abort) begin
                    swap_pending_d = 1'b0;
                    state_d        = StWaitA;
                end else if (handshake) begin
                    data_d   = in_data;
                    load_b_d = 1'b1;
                    state_d  = swap_pending_q ? StSwap : StDone;
                end
            end
            StSwap: begin
                swap_d         = 1'b1;
                swap_pending_d = 1'b0;
                state_d        = StDone;
            end
            StDone: begin
                done_d  = 1'b1;
                count_d = count_q + WIDTH'(1);
                state_d = StWaitA;
            end
            default: state_d = StWaitA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StWaitA;
            data_q         <= '0;
            count_q        <= '0;
            load_a_q       <= 1'b0;
            load_b_q       <= 1'b0;
            swap_q         <= 1'b0;
            done_q         <= 1'b0;
            swap_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            data_q         <= data_d;
            count_q        <= count_d;
            load_a_q       <= load_a_d;
            load_b_q       <= load_b_d;
            swap_q         <= swap_d;
            done_q         <= done_d;
            swap_pending_q <= swap_pending_d;
        end
    end

    assign data_out   = data_q;
    assign load_a     = load_a_q;
    assign load_b     = load_b_q;
    assign swap       = swap_q;
    assign pair_done  = done_q;
    assign pair_count = count_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a behavioural two-register operand file model.
module tb_operand_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       swap_req;
    logic       abort;
    logic [7:0] data_out;
    logic       load_a;
    logic       load_b;
    logic       swap;
    logic       pair_done;
    logic [7:0] pair_count;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] file_a = 8'h00;
    logic [7:0] file_b = 8'h00;
    logic [3:0] strb;

    operand_loader #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .swap_req  (swap_req),
        .abort     (abort),
        .data_out  (data_out),
        .load_a    (load_a),
        .load_b    (load_b),
        .swap      (swap),
        .pair_done (pair_done),
        .pair_count(pair_count)
    );

    always #5 clk = ~clk;

    assign strb = {load_a, load_b, swap, pair_done};

    // Downstream operand file: captures on the edge after a strobe.
    always @(posedge clk) begin
        if (load_a) file_a <= data_out;
        else if (load_b) file_b <= data_out;
        else if (swap) begin
            file_a <= file_b;
            file_b <= file_a;
        end
    end

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        swap_req = 1'b1;
        abort    = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        vectors++;
        if (strb !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_strobes got %b want 0000", strb);
        end
        vectors++;
        if (data_out !== 8'h00 || pair_count !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_regs got data=%h count=%h want 00/00", data_out, pair_count);
        end
        in_valid = 1'b0;
        swap_req = 1'b0;
        reset    = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_in_ready got %b want 1", in_ready);
        end
    endtask

    // Loads bytes a then b back-to-back and checks the strobe sequence and final file.
    task automatic run_pair(input logic [7:0] a, input logic [7:0] b, input logic sw,
                            input logic [7:0] cnt, input string name);
        in_valid = 1'b1;
        in_data  = a;
        swap_req = sw;
        @(negedge clk);
        vectors++;
        if (strb !== 4'b1000 || data_out !== a) begin
            miscompares++;
            $display("FAIL %s_load_a got strb=%b data=%h want 1000/%h", name, strb, data_out, a);
        end
        in_data  = b;
        swap_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (strb !== 4'b0100 || data_out !== b || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_load_b got strb=%b data=%h rdy=%b want 0100/%h/0",
                     name, strb, data_out, in_ready, b);
        end
        in_valid = 1'b0;
        if (sw) begin
            @(negedge clk);
            vectors++;
            if (strb !== 4'b0010 || data_out !== b) begin
                miscompares++;
                $display("FAIL %s_swap got strb=%b data=%h want 0010/%h", name, strb, data_out, b);
            end
        end
        @(negedge clk);
        vectors++;
        if (strb !== 4'b0001 || pair_count !== cnt || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_done got strb=%b count=%h rdy=%b want 0001/%h/1",
                     name, strb, pair_count, in_ready, cnt);
        end
        vectors++;
        if (file_a !== (sw ? b : a) || file_b !== (sw ? a : b)) begin
            miscompares++;
            $display("FAIL %s_file got A=%h B=%h want %h/%h", name, file_a, file_b,
                     sw ? b : a, sw ? a : b);
        end
    endtask

    task automatic test_basic();
        run_pair(8'h3C, 8'hA5, 1'b0, 8'd1, "basic");
    endtask

    task automatic test_swap();
        run_pair(8'h3C, 8'hA5, 1'b1, 8'd2, "swap");
    endtask

    task automatic test_abort();
        in_valid = 1'b1;
        in_data  = 8'h11;
        swap_req = 1'b1;
        @(negedge clk);
        vectors++;
        if (strb !== 4'b1000 || data_out !== 8'h11) begin
            miscompares++;
            $display("FAIL abort_load_a got strb=%b data=%h want 1000/11", strb, data_out);
        end
        swap_req = 1'b0;
        in_data  = 8'h22;
        abort    = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_in_ready got %b want 0", in_ready);
        end
        @(negedge clk);
        vectors++;
        if (strb !== 4'b0000 || data_out !== 8'h11 || pair_count !== 8'd2) begin
            miscompares++;
            $display("FAIL abort_no_load got strb=%b data=%h count=%h want 0000/11/02",
                     strb, data_out, pair_count);
        end
        abort   = 1'b0;
        in_data = 8'h33;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_recover_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        vectors++;
        if (strb !== 4'b1000 || data_out !== 8'h33) begin
            miscompares++;
            $display("FAIL abort_next_a got strb=%b data=%h want 1000/33", strb, data_out);
        end
        // Complete the pair; the earlier swap request must not leak into it.
        in_data = 8'h44;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (strb !== 4'b0001 || pair_count !== 8'd3) begin
            miscompares++;
            $display("FAIL abort_pair_done got strb=%b count=%h want 0001/03", strb, pair_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] p;
        reset = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        swap_req = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 256; i++) begin
            p = 8'(i);
            @(negedge clk);
            vectors++;
            if (strb !== 4'b1000 || data_out !== p) begin
                miscompares++;
                $display("FAIL b2b_load_a[%0d] got strb=%b data=%h want 1000/%h",
                         i, strb, data_out, p);
            end
            in_data = ~p;
            @(negedge clk);
            vectors++;
            if (strb !== 4'b0100 || data_out !== ~p) begin
                miscompares++;
                $display("FAIL b2b_load_b[%0d] got strb=%b data=%h want 0100/%h",
                         i, strb, data_out, ~p);
            end
            in_data = 8'hEE;
            @(negedge clk);
            vectors++;
            if (strb !== 4'b0001 || pair_count !== 8'(i + 1)) begin
                miscompares++;
                $display("FAIL b2b_done[%0d] got strb=%b count=%h want 0001/%h",
                         i, strb, pair_count, 8'(i + 1));
            end
            in_data = 8'(i + 1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (pair_count !== 8'h00 || strb !== 4'b0000) begin
            miscompares++;
            $display("FAIL b2b_wrap got count=%h strb=%b want 00/0000", pair_count, strb);
        end
    endtask

    task automatic test_reset_mid_pair();
        in_valid = 1'b1;
        in_data  = 8'h5A;
        swap_req = 1'b1;
        @(negedge clk);
        in_data  = 8'hC3;
        swap_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (strb !== 4'b0100) begin
            miscompares++;
            $display("FAIL rstmid_load_b got strb=%b want 0100", strb);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_ready got %b want 0", in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (strb !== 4'b0000 || data_out !== 8'h00 || pair_count !== 8'h00) begin
                miscompares++;
                $display("FAIL rstmid_outputs[%0d] got strb=%b data=%h count=%h want 0",
                         i, strb, data_out, pair_count);
            end
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_release_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        vectors++;
        if (strb !== 4'b0000) begin
            miscompares++;
            $display("FAIL rstmid_no_swap got strb=%b want 0000", strb);
        end
    endtask

    task automatic test_valid_toggle();
        logic       vpat [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] dpat [5] = '{8'h77, 8'h88, 8'h99, 8'hAA, 8'h96};
        in_valid = 1'b1;
        in_data  = 8'h5A;
        swap_req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            in_valid = vpat[i];
            in_data  = dpat[i];
            @(negedge clk);
            if (vpat[i]) begin
                vectors++;
                if (strb !== 4'b0100 || data_out !== dpat[i]) begin
                    miscompares++;
                    $display("FAIL toggle_load_b got strb=%b data=%h want 0100/%h",
                             strb, data_out, dpat[i]);
                end
            end else begin
                vectors++;
                if (load_b !== 1'b0 || data_out !== 8'h5A) begin
                    miscompares++;
                    $display("FAIL toggle_idle[%0d] got load_b=%b data=%h want 0/5a",
                             i, load_b, data_out);
                end
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (strb !== 4'b0001 || pair_count !== 8'd1 || file_b !== 8'h96) begin
            miscompares++;
            $display("FAIL toggle_done got strb=%b count=%h B=%h want 0001/01/96",
                     strb, pair_count, file_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_swap();
        test_abort();
        test_back_to_back();
        test_reset_mid_pair();
        test_valid_toggle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/operand_loader.md
# operand_loader

Sequencer that writes operand bytes into the two-register operand file (A, B) ahead of the ALU. It accepts a valid/ready byte stream and drives the file's write-side controls: data byte, load-A, load-B and swap strobes. Each pair of accepted bytes is written as A then B, optionally followed by an A/B swap. Completed pairs are counted and signalled upstream.

## Interface
- WIDTH, 8, operand byte width; also the width of `data_out` and `pair_count`.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
- in_data  input  WIDTH  operand byte from upstream.
- in_valid  input  1  `in_data` is valid.
- in_ready  output  1  block accepts a byte this cycle; combinational from state and `abort`.
- swap_req  input  1  request an A/B swap after this pair; sampled only on the A-byte handshake.
- abort  input  1  drop a half-loaded pair and return to waiting for an A byte.
- data_out  output  WIDTH  byte to the operand file's data input; registered.
- load_a  output  1  one-cycle load strobe for register A; registered.
- load_b  output  1  one-cycle load strobe for register B; registered.
- swap  output  1  one-cycle swap strobe; registered.
- pair_done  output  1  one-cycle pulse when a pair, including any swap, is finished.
- pair_count  output  WIDTH  number of completed pairs, modulo 2^WIDTH.

## Operation
- A handshake occurs in a cycle where `in_valid && in_ready` is high at the rising edge.
- States: WAIT_A, WAIT_B, SWAP, DONE. The reset state is WAIT_A.
- `in_ready` is 1 only in WAIT_A or WAIT_B, and only while `abort`==0 and `reset`==1. It is 0 otherwise.
- WAIT_A, on handshake:
  - `data_out`<=`in_data`, `load_a`<=1, `swap_pending`<=`swap_req`.
  - Next state WAIT_B.
- WAIT_B, on handshake:
  - `data_out`<=`in_data`, `load_b`<=1.
  - Next state SWAP if `swap_pending` is 1, else DONE.
- WAIT_B with `abort`==1:
  - No byte is accepted; `swap_pending`<=0; next state WAIT_A.
  - Register A keeps the byte already written; `pair_count` is unchanged.
- `abort` in WAIT_A, SWAP or DONE has no effect. A SWAP already entered always completes.
- SWAP: `swap`<=1, `swap_pending`<=0, next state DONE. `in_ready`=0.
- DONE: `pair_done`<=1, `pair_count`<=`pair_count`+1 (255 wraps to 0 for WIDTH=8), next state WAIT_A. `in_ready`=0.
- Strobes are mutually exclusive: at most one of `load_a`, `load_b`, `swap` is high in any cycle. Each is high for exactly one cycle per event.
- `data_out` holds its last value when no load strobe is active. It does not change on `swap`.
- A byte held with `in_valid`=1 while `in_ready`=0 is not consumed. Upstream must hold `in_data` stable until the handshake.
- Reset values: state WAIT_A, `data_out`=0, `load_a`=0, `load_b`=0, `swap`=0, `pair_done`=0, `pair_count`=0, `swap_pending`=0, `in_ready`=0 while `reset`==0.
- Reset mid-pair (any state) discards the partial pair and any pending swap. No strobe is emitted in the cycle after a reset edge.

## Timing
- Strobe latency: `load_a`/`load_b` are high in the cycle after their handshake edge, with the matching `data_out`. The operand file captures the byte on the following edge, so A/B update two edges after the handshake.
- `swap` is high one cycle after `load_b`. `pair_done` is high one cycle after `swap`, or one cycle after `load_b` when no swap is requested.
- `pair_count` increments on the same edge that raises `pair_done`.
- Maximum throughput with `in_valid` held high: one pair every 3 cycles without swap, every 4 cycles with swap.
- Earliest next A handshake is in the cycle after DONE, which is the same cycle `pair_done` is high.

## Test plan
- Reset, then present 0x3C and 0xA5 back-to-back with `swap_req`=0 -> `load_a` with `data_out`=0x3C, next cycle `load_b` with 0xA5, next cycle `pair_done`, `pair_count`=1; operand file ends with A=0x3C, B=0xA5.
- Same bytes with `swap_req`=1 on the A byte -> `load_a`, `load_b`, `swap`, `pair_done` on 4 consecutive cycles; file ends with A=0xA5, B=0x3C.
- After A byte 0x11, assert `abort` together with `in_valid` carrying 0x22 -> `in_ready`=0, no `load_b`, returns to WAIT_A, `pair_count` unchanged; next byte 0x33 produces `load_a`.
- Stream 256 pairs continuously -> one `pair_done` every 3 cycles, `pair_count` wraps to 0, no cycle with two strobes high.
- Drive `reset`=0 in the cycle `load_b` is high with `swap_req`=1 latched -> no `swap` or `pair_done` follows, all outputs 0, `in_ready`=0 during reset and 1 after release.
- Toggle `in_valid` randomly during WAIT_B -> `load_b` fires only on the first edge with `in_valid`=1, with the byte present at that edge.
